// File: rtl/ex_mem_if.sv
// ex_mem_if -- EX -> EX/MEM -> MEM bus.
//
// Carries the pipeline control (stall, flush), the EX-side result bundle
// (ex_*), the multiply-accumulate feedback pair (hilo_i/cnt_i in, hilo_o/cnt_o
// out) and the registered MEM-side bundle (mem_*, mem_valid).
//   master : the EX/ctrl side; drives control and ex_*, observes mem_* and feedback.
//   slave  : the EX/MEM pipeline register (ex_mem).
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // control from ctrl
  logic [5:0]          stall;
  logic                flush;
  // EX-side payload
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whi;
  logic                ex_wlo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  // madd/msub state travelling EX -> reg -> EX
  logic [2*DATA_W-1:0] hilo_i;
  logic [1:0]          cnt_i;
  logic [2*DATA_W-1:0] hilo_o;
  logic [1:0]          cnt_o;
  // MEM-side payload
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whi;
  logic                mem_wlo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_valid;

  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_whi, ex_wlo, ex_hi, ex_lo,
    output hilo_i, cnt_i,
    input  hilo_o, cnt_o,
    input  mem_wd, mem_wreg, mem_wdata, mem_whi, mem_wlo, mem_hi, mem_lo,
    input  mem_valid
  );

  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_whi, ex_wlo, ex_hi, ex_lo,
    input  hilo_i, cnt_i,
    output hilo_o, cnt_o,
    output mem_wd, mem_wreg, mem_wdata, mem_whi, mem_wlo, mem_hi, mem_lo,
    output mem_valid
  );
endinterface

// File: rtl/ex_mem.sv
// ex_mem -- EX/MEM pipeline register.
//
// Registers the EX result bundle toward MEM with one clock of latency and
// carries the multiply-accumulate partial product / cycle count back to EX
// across stalls. Every output is a flop; no input reaches an output
// combinationally.
//
// Ports:
//   clk  : single clock, rising edge.
//   rst  : synchronous active-high reset; zeroes every output.
//   bus  : ex_mem_if.slave -- stall/flush, ex_* in, mem_* out,
//          hilo_i/cnt_i in, hilo_o/cnt_o out.
//
// Per-edge priority: rst > flush > bubble > hold > advance.
//   bubble  (stall[3]=1, stall[4]=0): MEM gets a zeroed, invalid slot.
//   hold    (stall[3]=1, stall[4]=1): MEM payload frozen.
//   advance (stall[3]=0)            : MEM payload loads ex_*.
// While EX is stopped (bubble or hold) the madd/msub state is re-captured
// each cycle so the sequence survives the stall; an advance retires the
// instruction and therefore clears it.
module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic  clk,
  input  logic  rst,
  ex_mem_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whi;
    logic              wlo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } stage_t;

  typedef enum logic [1:0] {
    ADVANCE = 2'd0,
    HOLD    = 2'd1,
    BUBBLE  = 2'd2,
    FLUSH   = 2'd3
  } op_e;

  stage_t              stage_q, stage_d, ex_stage;
  logic                valid_q, valid_d;
  logic [2*DATA_W-1:0] hilo_q,  hilo_d;
  logic [1:0]          cnt_q,   cnt_d;
  op_e                 op;

  // Only the EX/MEM stop (bit 3) and the MEM stop (bit 4) matter here.
  logic unused_stall;
  assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

  assign ex_stage = '{wd:    bus.ex_wd,
                      wreg:  bus.ex_wreg,
                      wdata: bus.ex_wdata,
                      whi:   bus.ex_whi,
                      wlo:   bus.ex_wlo,
                      hi:    bus.ex_hi,
                      lo:    bus.ex_lo};

  // Decode the update kind. stall[3]=0 with stall[4]=1 cannot come from
  // ctrl; it falls through to ADVANCE.
  always_comb begin
    op = ADVANCE;
    if (bus.flush)                        op = FLUSH;
    else if (bus.stall[3] && !bus.stall[4]) op = BUBBLE;
    else if (bus.stall[3])                op = HOLD;
  end

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    unique case (op)
      FLUSH: begin
        stage_d = '0;
        valid_d = 1'b0;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      BUBBLE: begin
        stage_d = '0;
        valid_d = 1'b0;
        hilo_d  = bus.hilo_i;
        cnt_d   = bus.cnt_i;
      end
      HOLD: begin
        hilo_d  = bus.hilo_i;
        cnt_d   = bus.cnt_i;
      end
      default: begin
        // wreg with wd=0 is passed as-is; r0 suppression lives in the regfile.
        stage_d = ex_stage;
        valid_d = 1'b1;
        hilo_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset wins over everything, so a pending madd/msub partial product is
  // dropped without ever reaching mem_whi/mem_wlo.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_wd    = stage_q.wd;
  assign bus.mem_wreg  = stage_q.wreg;
  assign bus.mem_wdata = stage_q.wdata;
  assign bus.mem_whi   = stage_q.whi;
  assign bus.mem_wlo   = stage_q.wlo;
  assign bus.mem_hi    = stage_q.hi;
  assign bus.mem_lo    = stage_q.lo;
  assign bus.mem_valid = valid_q;
  assign bus.hilo_o    = hilo_q;
  assign bus.cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, advance, HI/LO, bubble, hold, illegal
// stall code, ignored stall bits, flush priority, reset mid madd and r0
// pass-through. Inputs change after the falling edge; outputs are sampled
// 1 time unit after the rising edge.
module tb_ex_mem;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_at_negedge();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wd"},    bus.mem_wd,    0);
    chk({tag, ".wreg"},  bus.mem_wreg,  0);
    chk({tag, ".wdata"}, bus.mem_wdata, 0);
    chk({tag, ".whi"},   bus.mem_whi,   0);
    chk({tag, ".wlo"},   bus.mem_wlo,   0);
    chk({tag, ".hi"},    bus.mem_hi,    0);
    chk({tag, ".lo"},    bus.mem_lo,    0);
    chk({tag, ".valid"}, bus.mem_valid, 0);
    chk({tag, ".hilo"},  bus.hilo_o,    0);
    chk({tag, ".cnt"},   bus.cnt_o,     0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.stall    = '0;
    bus.flush    = 1'b0;
    bus.ex_wd    = 5'd9;
    bus.ex_wreg  = 1'b1;
    bus.ex_wdata = 32'hDEADBEEF;
    bus.ex_whi   = 1'b1;
    bus.ex_wlo   = 1'b1;
    bus.ex_hi    = 32'h1;
    bus.ex_lo    = 32'h2;
    bus.hilo_i   = 64'h5;
    bus.cnt_i    = 2'd1;

    // reset overrides live inputs
    step();
    chk_all_zero("reset");

    // advance
    drive_at_negedge();
    rst = 1'b0;
    bus.ex_wd = 5'd5; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'h12345678;
    bus.ex_whi = 1'b0; bus.ex_wlo = 1'b0; bus.ex_hi = 32'h0; bus.ex_lo = 32'h0;
    bus.hilo_i = '0; bus.cnt_i = '0;
    step();
    chk("adv.wd",    bus.mem_wd,    5);
    chk("adv.wreg",  bus.mem_wreg,  1);
    chk("adv.wdata", bus.mem_wdata, 32'h12345678);
    chk("adv.valid", bus.mem_valid, 1);
    chk("adv.cnt",   bus.cnt_o,     0);

    // HI/LO path
    drive_at_negedge();
    bus.ex_whi = 1'b1; bus.ex_wlo = 1'b1; bus.ex_hi = 32'hFFFFFFFF; bus.ex_lo = 32'h2;
    step();
    chk("hilo.whi", bus.mem_whi, 1);
    chk("hilo.wlo", bus.mem_wlo, 1);
    chk("hilo.hi",  bus.mem_hi,  32'hFFFFFFFF);
    chk("hilo.lo",  bus.mem_lo,  32'h2);

    // bubble preserves madd state, clears MEM slot
    drive_at_negedge();
    bus.stall = 6'b001111; bus.hilo_i = 64'h00000001_FFFFFFFE; bus.cnt_i = 2'd1;
    step();
    chk("bub.wreg",  bus.mem_wreg,  0);
    chk("bub.wdata", bus.mem_wdata, 0);
    chk("bub.whi",   bus.mem_whi,   0);
    chk("bub.valid", bus.mem_valid, 0);
    chk("bub.hilo",  bus.hilo_o,    64'h00000001_FFFFFFFE);
    chk("bub.cnt",   bus.cnt_o,     1);
    drive_at_negedge();
    bus.stall = '0;
    step();
    chk("bub_rel.hilo",  bus.hilo_o,    0);
    chk("bub_rel.cnt",   bus.cnt_o,     0);
    chk("bub_rel.valid", bus.mem_valid, 1);

    // hold freezes MEM payload for 3 cycles, feedback still tracks EX
    drive_at_negedge();
    bus.ex_wdata = 32'hA5A5A5A5; bus.hilo_i = '0; bus.cnt_i = '0;
    step();
    chk("hold.load", bus.mem_wdata, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      drive_at_negedge();
      bus.stall = 6'b011111;
      bus.ex_wdata = 32'h1000 + 32'(i);
      bus.hilo_i = 64'h20 + 64'(i);
      bus.cnt_i = 2'd2;
      step();
      chk("hold.wdata", bus.mem_wdata, 32'hA5A5A5A5);
      chk("hold.valid", bus.mem_valid, 1);
      chk("hold.hilo",  bus.hilo_o,    64'h20 + 64'(i));
      chk("hold.cnt",   bus.cnt_o,     2);
    end

    // illegal stall[4]=1, stall[3]=0 behaves as advance
    drive_at_negedge();
    bus.stall = 6'b010000; bus.ex_wdata = 32'h55; bus.hilo_i = 64'h77; bus.cnt_i = 2'd1;
    step();
    chk("ill.wdata", bus.mem_wdata, 32'h55);
    chk("ill.hilo",  bus.hilo_o,    0);
    chk("ill.cnt",   bus.cnt_o,     0);

    // other stall bits ignored: still advance
    drive_at_negedge();
    bus.stall = 6'b100111; bus.ex_wdata = 32'h66;
    step();
    chk("ign.wdata", bus.mem_wdata, 32'h66);
    chk("ign.valid", bus.mem_valid, 1);

    // flush beats hold and clears feedback
    drive_at_negedge();
    bus.stall = 6'b011111; bus.flush = 1'b1; bus.hilo_i = 64'hABCD_0000_1234; bus.cnt_i = 2'd3;
    step();
    chk_all_zero("flush");

    // reset mid madd: build cnt_o=1 via bubble, then rst+flush+bubble
    drive_at_negedge();
    bus.flush = 1'b0; bus.stall = 6'b001111; bus.hilo_i = 64'h0000_0003_0000_0004; bus.cnt_i = 2'd1;
    step();
    chk("madd.cnt",  bus.cnt_o,  1);
    chk("madd.hilo", bus.hilo_o, 64'h0000_0003_0000_0004);
    drive_at_negedge();
    rst = 1'b1; bus.flush = 1'b1;
    bus.ex_whi = 1'b1; bus.ex_wlo = 1'b1;
    step();
    chk_all_zero("rst_mid");
    drive_at_negedge();
    rst = 1'b0; bus.flush = 1'b0; bus.stall = '0;
    bus.ex_wd = 5'd7; bus.ex_wdata = 32'hCAFE; bus.ex_whi = 1'b0; bus.ex_wlo = 1'b0;
    step();
    chk("rst_rel.wd",    bus.mem_wd,    7);
    chk("rst_rel.wdata", bus.mem_wdata, 32'hCAFE);
    chk("rst_rel.valid", bus.mem_valid, 1);

    // r0 write passes through
    drive_at_negedge();
    bus.ex_wd = 5'd0; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'h99;
    step();
    chk("r0.wd",    bus.mem_wd,    0);
    chk("r0.wreg",  bus.mem_wreg,  1);
    chk("r0.wdata", bus.mem_wdata, 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter DATA_W, default 32, general register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register file address width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high; the block has one clock.
REQ-005 Port stall  input  6  pipeline stall vector from ctrl; bit 3 = EX/MEM stage stop, bit 4 = MEM stage stop.
REQ-006 Port flush  input  1  pipeline flush request, active-high.
REQ-007 Port ex_wd  input  ADDR_W  destination register address from EX.
REQ-008 Port ex_wreg  input  1  register write enable from EX, already overflow-gated.
REQ-009 Port ex_wdata  input  DATA_W  result data from EX.
REQ-010 Port ex_whi / ex_wlo  input  1 each  HI/LO write enables from EX.
REQ-011 Port ex_hi / ex_lo  input  DATA_W each  HI/LO write data from EX.
REQ-012 Port hilo_i  input  2*DATA_W  partial multiply-accumulate product from EX (madd/msub first cycle).
REQ-013 Port cnt_i  input  2  multiply-accumulate cycle count from EX.
REQ-014 Port mem_wd, mem_wreg, mem_wdata, mem_whi, mem_wlo, mem_hi, mem_lo  output  widths as matching ex_* ports  registered copies toward MEM.
REQ-015 Port mem_valid  output  1  high when the MEM-side outputs hold a real instruction, not a bubble.
REQ-016 Port hilo_o  output  2*DATA_W  registered partial product fed back to EX.
REQ-017 Port cnt_o  output  2  registered cycle count fed back to EX.

Function
REQ-018 All outputs SHALL be registers; latency from ex_* to mem_* SHALL be exactly one clock when advancing.
REQ-019 The priority of the per-edge update SHALL be rst > flush > bubble > hold > advance.
REQ-020 flush=1: all mem_* outputs SHALL be cleared to zero, mem_valid=0, hilo_o=0, cnt_o=0, whatever the stall value.
REQ-021 Bubble (stall[3]=1 and stall[4]=0): all mem_* outputs SHALL be cleared to zero and mem_valid=0.
REQ-022 In a bubble, hilo_o SHALL load hilo_i and cnt_o SHALL load cnt_i, preserving the multiply-accumulate state across the EX stall.
REQ-023 Hold (stall[3]=1 and stall[4]=1): all mem_* outputs and mem_valid SHALL keep their previous values.
REQ-024 In a hold, hilo_o SHALL load hilo_i and cnt_o SHALL load cnt_i.
REQ-025 Advance (stall[3]=0): each mem_* output SHALL load its ex_* counterpart and mem_valid SHALL become 1.
REQ-026 In an advance, hilo_o and cnt_o SHALL clear to zero, ending any multiply-accumulate sequence.
REQ-027 stall[3]=0 with stall[4]=1 is illegal from ctrl; the block SHALL treat it as an advance.
REQ-028 Bits of stall other than 3 and 4 SHALL be ignored.
REQ-029 mem_wreg=1 with mem_wd=0 SHALL be passed through unchanged; register-0 suppression belongs to the register file.
REQ-030 No combinational path SHALL exist from any input to any output.

Reset
REQ-031 On a rising edge with rst=1, every output (mem_*, mem_valid, hilo_o, cnt_o) SHALL become zero, overriding flush and stall.
REQ-032 When rst is asserted mid multiply-accumulate (cnt_o=1), the pending partial product SHALL be discarded with no write visible on mem_whi/mem_wlo.

Verification
REQ-033 Advance: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x12345678 -> next edge: mem_wd=5, mem_wreg=1, mem_wdata=0x12345678, mem_valid=1, cnt_o=0.
REQ-034 Bubble: stall=6'b001111, hilo_i=0x00000001_FFFFFFFE, cnt_i=1 -> next edge: mem_wreg=0, mem_wdata=0, mem_valid=0, hilo_o=0x00000001_FFFFFFFE, cnt_o=1; then stall=0 -> hilo_o=0, cnt_o=0.
REQ-035 Hold: load mem_wdata=0xA5A5A5A5, then stall=6'b011111 for 3 cycles with ex_wdata changing each cycle -> mem_wdata stays 0xA5A5A5A5 and mem_valid stays 1 throughout.
REQ-036 Flush vs stall: flush=1 with stall=6'b011111 and nonzero hilo_i/cnt_i -> next edge: all outputs zero.
REQ-037 Reset mid-sequence: cnt_o=1, hilo_o nonzero, rst=1 together with flush=1 and stall=6'b001111 -> next edge: all outputs zero; rst released with stall=0 -> next edge loads ex_* normally.
REQ-038 HI/LO path: stall=0, ex_whi=1, ex_wlo=1, ex_hi=0xFFFFFFFF, ex_lo=0x00000002 -> next edge: mem_whi=1, mem_wlo=1, mem_hi=0xFFFFFFFF, mem_lo=0x00000002.
